// File: rtl/vip_capture_buf.sv
// vip_capture_buf: passive AXI-Stream tap that snapshots FRAMES frames of SAMP
// samples after an arm command and serves them through a registered read port.
module vip_capture_buf #(
  parameter int unsigned TDATA_WIDTH = 16,
  parameter int unsigned SAMP        = 32,
  parameter int unsigned FRAMES      = 1,
  parameter bit          ALIGN       = 1'b1,
  parameter bit          AUTO_ARM    = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [TDATA_WIDTH-1:0]               s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  input  logic                                 arm,
  output logic                                 vip_full,
  output logic                                 frame_err,
  output logic [$clog2(SAMP*FRAMES+1)-1:0]     wr_count,
  input  logic [$clog2(SAMP*FRAMES)-1:0]       rd_addr,
  output logic [TDATA_WIDTH-1:0]               rd_data
);

  localparam int unsigned DEPTH = SAMP * FRAMES;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = $clog2(SAMP);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FULL    = 2'd3
  } state_t;

  // Where reset and arm land, depending on alignment and auto-arm options.
  localparam state_t ARM_STATE   = ALIGN ? S_ARMED : S_CAPTURE;
  localparam state_t RESET_STATE = AUTO_ARM ? ARM_STATE : S_IDLE;

  state_t                   r_state;
  logic                     r_tready;
  logic                     r_full;
  logic                     r_err;
  logic [CW-1:0]            r_count;
  logic [PW-1:0]            r_pos;
  logic [TDATA_WIDTH-1:0]   r_rd_data;
  logic [TDATA_WIDTH-1:0]   r_ram [DEPTH];

  logic                     w_beat;
  logic                     w_wr_en;
  logic                     w_pos_last;
  logic                     w_last_wr;
  logic                     w_misalign;

  assign w_beat     = s_axis_tvalid && r_tready;
  assign w_wr_en    = (r_state == S_CAPTURE) && w_beat && !arm && !rst;
  assign w_pos_last = (r_pos == PW'(SAMP - 1));
  assign w_last_wr  = (r_count == CW'(DEPTH - 1));
  // tlast must coincide exactly with the last sample slot of each frame.
  assign w_misalign = ALIGN && (s_axis_tlast != w_pos_last);

  assign s_axis_tready = r_tready;
  assign vip_full      = r_full;
  assign frame_err     = r_err;
  assign wr_count      = r_count;
  assign rd_data       = r_rd_data;

  // Capture control FSM with registered status outputs; arm overrides everything but rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RESET_STATE;
      r_tready <= 1'b0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= '0;
      r_pos    <= '0;
    end else begin
      r_tready <= 1'b1;
      if (arm) begin
        r_state <= ARM_STATE;
        r_full  <= 1'b0;
        r_err   <= 1'b0;
        r_count <= '0;
        r_pos   <= '0;
      end else begin
        case (r_state)
          S_ARMED: begin
            if (w_beat && s_axis_tlast) begin
              r_state <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (w_beat) begin
              r_count <= r_count + CW'(1);
              r_pos   <= w_pos_last ? '0 : r_pos + PW'(1);
              if (w_misalign) begin
                r_err <= 1'b1;
              end
              if (w_last_wr) begin
                r_state <= S_FULL;
                r_full  <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Sample store; never cleared so a snapshot survives rst and arm.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ram[r_count[AW-1:0]] <= s_axis_tdata;
    end
  end

  // Registered read port; read-first against a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_ram[rd_addr];
    end
  end

endmodule

// File: doc/vip_capture_buf.md
# vip_capture_buf

Parametrised single-clock snapshot buffer for the DSP pipeline's virtual instrument probe (VIP). It sits passively on an AXI-Stream tap, captures FRAMES whole frames of SAMP samples after an arm command, optionally aligned to the tlast frame boundary, and holds them for the bench or readout logic. Capture state is exposed through a full flag, a live count and a sticky framing-error flag. Stored samples are read back through a registered random-access read port.

## Interface
- TDATA_WIDTH, 16, sample width in bits
- SAMP, 32, samples per frame (FFT length); must be ≥ 2
- FRAMES, 1, frames per capture; DEPTH = SAMP*FRAMES (derived localparam)
- ALIGN, 1, 1 = capture starts on the first beat after a tlast; 0 = capture starts on the first beat after arm
- AUTO_ARM, 1, 1 = block leaves reset armed; 0 = block leaves reset idle

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  TDATA_WIDTH  tapped sample
- s_axis_tvalid  in  1  sample valid
- s_axis_tlast  in  1  last sample of frame
- s_axis_tready  out  1  always 1 except during rst; the block never back-pressures
- arm  in  1  single-cycle pulse; starts or restarts a capture
- vip_full  out  1  capture complete, buffer holds DEPTH samples
- frame_err  out  1  sticky: misaligned tlast seen during capture
- wr_count  out  $clog2(DEPTH+1)  samples written in the current capture
- rd_addr  in  $clog2(DEPTH)  read address
- rd_data  out  TDATA_WIDTH  registered ram[rd_addr]

## Operation
- Beat = s_axis_tvalid && s_axis_tready. Beats outside CAPTURE are dropped and not stored.
- States: IDLE, ARMED, CAPTURE, FULL.
- Reset exits to ARMED if AUTO_ARM=1, else to IDLE.
  - When AUTO_ARM=1 and ALIGN=0, reset exits directly to CAPTURE.
- arm in any state does all of the following:
  - clears wr_count, vip_full and frame_err;
  - enters ARMED (ALIGN=1) or CAPTURE (ALIGN=0).
- ARMED (ALIGN=1):
  - a beat with tlast=1 moves to CAPTURE; that beat is not stored;
  - beats with tlast=0 are ignored.
- CAPTURE:
  - each beat writes ram[wr_count] and increments wr_count;
  - the beat that writes address DEPTH-1 moves to FULL.
- FULL: beats are ignored, RAM contents are held, and only arm or rst leaves the state.
- frame_err is set in CAPTURE, ALIGN=1 only, by either of these:
  - a beat with tlast=1 where (wr_count mod SAMP) ≠ SAMP-1;
  - a beat with tlast=0 where (wr_count mod SAMP) = SAMP-1.
  - The sample is still stored; the capture continues; frame_err stays set until arm or rst.
- frame_err is never set when ALIGN=0.
- Read port: rd_data is registered ram[rd_addr] in all states.
  - A read and a write to the same address in the same cycle returns the old data (read-first).
- The RAM is not cleared by rst or arm.

## Timing
- Reset values:
  - s_axis_tready=0 while rst is high and 1 from the first cycle after it;
  - vip_full=0, frame_err=0, wr_count=0, rd_data=0.
- Write latency:
  - the sample on a CAPTURE beat at edge N is in RAM after edge N;
  - wr_count shows the new value after edge N.
- vip_full rises in the cycle after the edge that stored the DEPTH-th sample (registered from the state).
- Read latency is 1 cycle: rd_addr sampled at edge N appears on rd_data after edge N.
- arm together with a beat: arm wins.
  - The beat is not stored.
  - With ALIGN=0, capture begins with the next beat.
- arm on the same edge as the final write: arm wins; vip_full stays 0 and wr_count becomes 0.
- rst mid-capture aborts the capture:
  - all state returns to reset values on the next edge;
  - previously written RAM words keep their values.
- wr_count saturates at DEPTH in FULL and never wraps.

## Test plan
- Default parameters, continuous tvalid, tlast every 32nd beat, data = beat index from 0 after reset. Required:
  - vip_full rises after the first tlast plus 32 beats;
  - ram[0..31] = 32..63, ram[i] = i+32;
  - frame_err=0.
- FRAMES=3, ALIGN=0, AUTO_ARM=0, arm pulse at cycle 5, tvalid toggling every other cycle. Required:
  - 96 samples stored in order;
  - wr_count steps 0→96;
  - samples arriving before arm are absent.
- ALIGN=1, tlast injected on the 20th captured beat. Required:
  - frame_err rises one cycle later and stays high;
  - capture still completes at 32;
  - a later arm clears frame_err.
- Re-arm, with arm asserted while vip_full=1 and again mid-capture at wr_count=17. Required:
  - each arm returns wr_count to 0 and vip_full to 0;
  - the final buffer holds the last full capture only.
- rst at wr_count=10. Required:
  - all outputs go to reset values;
  - ram[0..9] are unchanged when read back, one-cycle read latency confirmed;
  - AUTO_ARM=1 re-enters ARMED.
- Same-edge collisions, covering all three:
  - arm coincident with the final write: vip_full stays 0;
  - read of address k on the edge it is written: returns the old value, new value on the following read;
  - arm coincident with a beat: the beat is not stored.
